// File: rtl/fifo_rr_merger.sv
// N-channel round-robin merger of FWFT source FIFOs into one registered ready/valid stream.
// Optional build macro FIFO_RR_MERGER_TAG_EN stamps the granted channel index into the top ID_W bits of OUT_DATA.
module fifo_rr_merger #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                           BUS_CLK,
  input  logic                           BUS_RST_N,
  input  logic [CHANNELS-1:0]            CH_ENABLE,
  input  logic [CHANNELS-1:0]            IN_EMPTY,
  input  logic [CHANNELS*DATA_WIDTH-1:0] IN_DATA,
  input  logic [CHANNELS-1:0]            IN_HOLD,
  output logic [CHANNELS-1:0]            IN_READ,
  output logic [DATA_WIDTH-1:0]          OUT_DATA,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic [CHANNELS-1:0]            GRANT,
  output logic                           BUSY
);

  localparam int ID_W = $clog2(CHANNELS);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  typedef enum logic {S_IDLE, S_GRANTED} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       gidx_q, gidx_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic [7:0]            burst_q, burst_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  logic [CHANNELS-1:0]   req;
  logic                  hit;
  logic [ID_W-1:0]       hit_idx;
  logic [ID_W-1:0]       cand;
  logic                  slot_free;
  logic                  pop;
  logic                  release_g;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DATA_WIDTH-1:0] load_word;

  assign req = CH_ENABLE & ~IN_EMPTY;

  // Round-robin search starting just after the last released channel.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    cand    = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      cand = ID_W'((int'(last_q) + i) % CHANNELS);
      if (!hit && req[cand]) begin
        hit     = 1'b1;
        hit_idx = cand;
      end
    end
  end

  assign sel_data = IN_DATA[gidx_q*DATA_WIDTH +: DATA_WIDTH];

`ifdef FIFO_RR_MERGER_TAG_EN
  assign load_word = {gidx_q, sel_data[DATA_WIDTH-ID_W-1:0]};
`else
  assign load_word = sel_data;
`endif

  // State register.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q <= S_IDLE;
      gidx_q  <= '0;
      last_q  <= ID_W'(CHANNELS - 1);
      burst_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Next state: output register and grant bookkeeping.
  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    burst_d = burst_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && OUT_READY) valid_d = 1'b0;
    if (pop) begin
      data_d  = load_word;
      valid_d = 1'b1;
      if (burst_q != BURST_LAST) burst_d = burst_q + 8'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          state_d = S_GRANTED;
          gidx_d  = hit_idx;
          burst_d = '0;
        end
      end
      S_GRANTED: begin
        if (release_g) begin
          state_d = S_IDLE;
          last_d  = gidx_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs. A word moves downstream on a cycle where OUT_VALID and OUT_READY are both high;
  // the register may be refilled in that same cycle, so a pop needs only an empty or draining slot.
  always_comb begin
    slot_free = ~valid_q | OUT_READY;
    pop       = 1'b0;
    release_g = 1'b0;
    IN_READ   = '0;
    GRANT     = '0;
    if (state_q == S_GRANTED) begin
      pop       = ~IN_EMPTY[gidx_q] & CH_ENABLE[gidx_q] & slot_free;
      release_g = ~CH_ENABLE[gidx_q]
                | (~IN_HOLD[gidx_q] & IN_EMPTY[gidx_q])
                | (~IN_HOLD[gidx_q] & pop & (burst_q == BURST_LAST));
      GRANT     = CHANNELS'(1) << gidx_q;
      if (pop) IN_READ = CHANNELS'(1) << gidx_q;
    end
    OUT_DATA  = data_q;
    OUT_VALID = valid_q;
    BUSY      = (state_q == S_GRANTED) | valid_q;
  end

endmodule

// File: tb/tb_fifo_rr_merger.sv
// Bench for fifo_rr_merger: bench-side source FIFOs, a behavioural merger model with an
// expected-output queue compared every cycle, directed scenarios pinned by literal expectations.
`timescale 1ns/1ps
module tb_fifo_rr_merger;
  localparam int CH = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic            BUS_CLK;
  logic            BUS_RST_N;
  logic [CH-1:0]   CH_ENABLE;
  logic [CH-1:0]   IN_EMPTY;
  logic [CH*DW-1:0] IN_DATA;
  logic [CH-1:0]   IN_HOLD;
  logic [CH-1:0]   IN_READ;
  logic [DW-1:0]   OUT_DATA;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [CH-1:0]   GRANT;
  logic            BUSY;

  fifo_rr_merger #(.CHANNELS(CH), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .CH_ENABLE(CH_ENABLE), .IN_EMPTY(IN_EMPTY),
    .IN_DATA(IN_DATA), .IN_HOLD(IN_HOLD), .IN_READ(IN_READ), .OUT_DATA(OUT_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .GRANT(GRANT), .BUSY(BUSY)
  );

  // clock / reset
  initial BUS_CLK = 1'b0;
  always #5 BUS_CLK = ~BUS_CLK;

  int pass_cnt = 0;
  int total_cnt = 0;

  // source FIFOs
  logic [DW-1:0] src_mem [CH][64];
  int rd_p [CH];
  int wr_p [CH];

  // behavioural model: granted channel (-1 idle), last released, pops in this grant, output register
  int m_g, m_last, m_cnt;
  logic [DW-1:0] exp_q [$];

  // trace logs for directed checks
  int tcyc;
  logic [CH-1:0] log_grant [64];
  logic [CH-1:0] log_rd [64];
  logic          log_ov [64];
  logic          log_rdy [64];
  logic [DW-1:0] log_od [64];
  logic [DW-1:0] sink_log [64];
  int sink_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  function automatic bit src_empty(input int ch);
    return rd_p[ch] == wr_p[ch];
  endfunction

  function automatic logic [DW-1:0] tagw(input int ch, input logic [DW-1:0] w);
    logic [1:0] c2;
    c2 = 2'(ch);
`ifdef FIFO_RR_MERGER_TAG_EN
    return {c2, w[DW-3:0]};
`else
    c2 = c2;
    return w;
`endif
  endfunction

  task automatic drive_srcs();
    for (int k = 0; k < CH; k++) begin
      IN_EMPTY[k] = src_empty(k);
      IN_DATA[k*DW +: DW] = src_mem[k][rd_p[k] % 64];
    end
  endtask

  task automatic push(input int ch, input logic [DW-1:0] w);
    src_mem[ch][wr_p[ch] % 64] = w;
    wr_p[ch]++;
    drive_srcs();
  endtask

  task automatic m_reset();
    m_g = -1;
    m_last = CH - 1;
    m_cnt = 0;
    exp_q.delete();
  endtask

  // One clock cycle: called at a falling edge with inputs settled.
  task automatic cycle();
    logic [CH-1:0] e_grant, e_rd;
    logic e_ov, e_busy;
    bit pop, xfer, rel;
    int g, nm_g, nm_last, nm_cnt, c;
    #1;
    g = m_g;
    e_ov = exp_q.size() != 0;
    e_grant = (g < 0) ? '0 : 4'(1 << g);
    pop = (g >= 0) && CH_ENABLE[g] && !src_empty(g) && (!e_ov || OUT_READY);
    e_rd = pop ? 4'(1 << g) : '0;
    e_busy = (g >= 0) || e_ov;
    chk("grant", GRANT, e_grant);
    chk("in_read", IN_READ, e_rd);
    chk("out_valid", OUT_VALID, e_ov);
    chk("busy", BUSY, e_busy);
    if (e_ov) chk("out_data", OUT_DATA, exp_q[0]);
    if (tcyc < 64) begin
      log_grant[tcyc] = GRANT;
      log_rd[tcyc] = IN_READ;
      log_ov[tcyc] = OUT_VALID;
      log_rdy[tcyc] = OUT_READY;
      log_od[tcyc] = OUT_DATA;
    end
    if (OUT_VALID && OUT_READY && sink_n < 64) begin
      sink_log[sink_n] = OUT_DATA;
      sink_n++;
    end
    xfer = e_ov && OUT_READY;
    nm_g = m_g; nm_last = m_last; nm_cnt = m_cnt;
    if (g < 0) begin
      for (int k = 1; k <= CH; k++) begin
        c = (m_last + k) % CH;
        if (nm_g < 0 && CH_ENABLE[c] && !src_empty(c)) begin
          nm_g = c;
          nm_cnt = 0;
        end
      end
    end else begin
      rel = !CH_ENABLE[g] || (!IN_HOLD[g] && src_empty(g)) ||
            (!IN_HOLD[g] && pop && m_cnt == MB - 1);
      if (pop && m_cnt < MB - 1) nm_cnt = m_cnt + 1;
      if (rel) begin
        nm_g = -1;
        nm_last = g;
      end
    end
    @(posedge BUS_CLK);
    #1;
    if (xfer) void'(exp_q.pop_front());
    if (pop) begin
      exp_q.push_back(tagw(g, src_mem[g][rd_p[g] % 64]));
      rd_p[g]++;
    end
    m_g = nm_g; m_last = nm_last; m_cnt = nm_cnt;
    drive_srcs();
    tcyc++;
    @(negedge BUS_CLK);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic hard_reset();
    BUS_RST_N = 1'b0;
    CH_ENABLE = '1;
    IN_HOLD = '0;
    OUT_READY = 1'b1;
    for (int k = 0; k < CH; k++) begin
      rd_p[k] = 0;
      wr_p[k] = 0;
    end
    drive_srcs();
    m_reset();
    @(negedge BUS_CLK);
    chk("rst_grant", GRANT, 0);
    chk("rst_in_read", IN_READ, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_data", OUT_DATA, 0);
    chk("rst_busy", BUSY, 0);
    @(negedge BUS_CLK);
    BUS_RST_N = 1'b1;
    tcyc = 0;
    sink_n = 0;
  endtask

  // Reset pulse between clock edges; outputs must clear without waiting for a clock.
  task automatic mid_reset();
    #3 BUS_RST_N = 1'b0;
    #1;
    chk("arst_grant", GRANT, 0);
    chk("arst_in_read", IN_READ, 0);
    chk("arst_out_valid", OUT_VALID, 0);
    chk("arst_out_data", OUT_DATA, 0);
    chk("arst_busy", BUSY, 0);
    m_reset();
    @(negedge BUS_CLK);
    BUS_RST_N = 1'b1;
    tcyc = 0;
  endtask

  localparam logic [31:0] T1_BASE =
`ifdef FIFO_RR_MERGER_TAG_EN
    32'h2000_0000;
`else
    32'hA000_0000;
`endif
  localparam logic [31:0] TAG_EXP =
`ifdef FIFO_RR_MERGER_TAG_EN
    32'hBFFF_FFFF;
`else
    32'hFFFF_FFFF;
`endif

  int cnt;
  int idx;
  logic [CH-1:0] e4;

  initial begin
    for (int k = 0; k < CH; k++)
      for (int j = 0; j < 64; j++) src_mem[k][j] = '0;
    sink_n = 0;
    tcyc = 0;
    hard_reset();

    // single channel, three words
    for (int i = 1; i <= 3; i++) push(0, 32'hA000_0000 + 32'(i));
    run(7);
    chk("t1_idle_grant", log_grant[0], 4'b0000);
    chk("t1_idle_read", log_rd[0], 4'b0000);
    for (int c = 1; c <= 4; c++) chk("t1_grant", log_grant[c], 4'b0001);
    for (int c = 1; c <= 3; c++) chk("t1_read", log_rd[c], 4'b0001);
    chk("t1_read_end", log_rd[4], 4'b0000);
    chk("t1_ov_first", log_ov[1], 1'b0);
    for (int c = 2; c <= 4; c++) begin
      chk("t1_ov", log_ov[c], 1'b1);
      chk("t1_data", log_od[c], T1_BASE + 32'(c - 1));
    end
    chk("t1_grant_off", log_grant[5], 4'b0000);
    chk("t1_ov_off", log_ov[5], 1'b0);

    // channel tag
    hard_reset();
    push(2, 32'hFFFF_FFFF);
    run(4);
    chk("tag_read", log_rd[1], 4'b0100);
    chk("tag_data", log_od[2], TAG_EXP);

    // burst limiting: period of 4 pops plus one idle cycle, order 0,1,2,3,0
    hard_reset();
    for (int k = 0; k < CH; k++)
      for (int j = 0; j < 12; j++) push(k, {4'(k), 28'(j)});
    run(25);
    for (int c = 0; c < 25; c++) begin
      e4 = (c % 5 == 0) ? 4'b0000 : 4'(1 << ((c / 5) % 4));
      chk("burst_read", log_rd[c], e4);
    end

    // packet hold through an empty gap with channel 2 waiting
    hard_reset();
    push(1, 32'h1111_0000);
    push(1, 32'h1111_0001);
    for (int j = 0; j < 10; j++) push(2, 32'h2222_0000 + 32'(j));
    IN_HOLD = 4'b0010;
    run(8);
    push(1, 32'h1111_0002);
    push(1, 32'h1111_0003);
    run(2);
    IN_HOLD = 4'b0000;
    run(4);
    cnt = 0;
    for (int c = 1; c <= 10; c++) chk("hold_grant", log_grant[c], 4'b0010);
    for (int c = 0; c <= 10; c++) if (log_rd[c][2]) cnt++;
    chk("hold_ch2_pops", cnt, 0);
    chk("hold_ch1_read8", log_rd[8], 4'b0010);
    chk("hold_next_grant", log_grant[12], 4'b0100);

    // output stall pattern 1,0,0,1
    hard_reset();
    for (int j = 0; j < 20; j++) push(0, 32'h5000_0000 + 32'(j));
    for (int c = 0; c < 24; c++) begin
      OUT_READY = (c % 4 == 0) || (c % 4 == 3);
      cycle();
    end
    OUT_READY = 1'b1;
    cnt = 0;
    for (int c = 0; c < 24; c++) if (log_ov[c] && !log_rdy[c] && log_rd[c] != 0) cnt++;
    chk("stall_pop_when_full", cnt, 0);
    chk("stall_sink_nonzero", 32'(sink_n > 0), 1);
    for (int i = 0; i < sink_n; i++) chk("stall_sink_seq", sink_log[i], tagw(0, 32'h5000_0000 + 32'(i)));

    // enable drop mid-burst, then asynchronous reset mid-burst
    hard_reset();
    for (int j = 0; j < 20; j++) push(3, 32'h3333_0000 + 32'(j));
    run(3);
    CH_ENABLE = 4'b0111;
    run(8);
    chk("en_grant_before", log_grant[2], 4'b1000);
    chk("en_grant_rel", log_grant[3], 4'b1000);
    chk("en_no_pop", log_rd[3], 4'b0000);
    for (int c = 4; c <= 10; c++) chk("en_no_regrant", log_grant[c], 4'b0000);
    CH_ENABLE = 4'b1111;
    run(2);
    push(0, 32'h0000_00AA);
    push(2, 32'h0000_00BB);
    run(1);
    chk("en_regrant", log_grant[13], 4'b1000);
    mid_reset();
    run(3);
    chk("arst_next_grant", log_grant[1], 4'b0001);

    // randomized traffic
    hard_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < CH; k++)
        if ($urandom_range(0, 3) == 0 && (wr_p[k] - rd_p[k]) < 60) push(k, $urandom);
      if ($urandom_range(0, 31) == 0) begin
        idx = $urandom_range(0, CH - 1);
        CH_ENABLE[idx] = ~CH_ENABLE[idx];
      end
      if ($urandom_range(0, 15) == 0) IN_HOLD = 4'($urandom) & 4'($urandom);
      OUT_READY = ($urandom_range(0, 3) != 0);
      if (i % 700 == 350) mid_reset();
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
